// File: rtl/clause_class_sum_pkg.sv
// Shared state encoding, default sizing and sum-width rule for the clause class-sum block.
package clause_class_sum_pkg;

   localparam int DEF_NUM_CLAUSES = 16;
   localparam int DEF_NUM_CLASSES = 10;
   localparam int DEF_WEIGHT_W    = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCUM  = 3'd1,
      ST_SUM    = 3'd2,
      ST_ARGMAX = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Headroom for NUM_CLAUSES full-scale weights of either sign.
   function automatic int sum_width(input int weight_w, input int num_clauses);
      return weight_w + $clog2(num_clauses) + 1;
   endfunction

endpackage

// File: rtl/clause_class_sum_if.sv
// Clause input, weight-load and result handshake bundle for clause_class_sum.
interface clause_class_sum_if #(
   parameter int NUM_CLAUSES = clause_class_sum_pkg::DEF_NUM_CLAUSES,
   parameter int NUM_CLASSES = clause_class_sum_pkg::DEF_NUM_CLASSES,
   parameter int WEIGHT_W    = clause_class_sum_pkg::DEF_WEIGHT_W
) ();

   localparam int SUM_W = clause_class_sum_pkg::sum_width(WEIGHT_W, NUM_CLAUSES);
   localparam int CL_W  = $clog2(NUM_CLAUSES);
   localparam int CS_W  = $clog2(NUM_CLASSES);

   logic                       img_start;
   logic                       clause_valid;
   logic [NUM_CLAUSES-1:0]     clause_vec;
   logic                       clause_last;
   logic                       w_we;
   logic [CS_W-1:0]            w_class;
   logic [CL_W-1:0]            w_clause;
   logic signed [WEIGHT_W-1:0] w_data;
   logic                       busy;
   logic                       result_valid;
   logic                       result_ready;
   logic [CS_W-1:0]            class_pred;
   logic signed [SUM_W-1:0]    class_sum_max;

   modport master (
      output img_start, clause_valid, clause_vec, clause_last,
      output w_we, w_class, w_clause, w_data, result_ready,
      input  busy, result_valid, class_pred, class_sum_max
   );

   modport slave (
      input  img_start, clause_valid, clause_vec, clause_last,
      input  w_we, w_class, w_clause, w_data, result_ready,
      output busy, result_valid, class_pred, class_sum_max
   );

endinterface

// File: rtl/clause_class_sum_weight_ram.sv
// Class x clause signed weight registers: one synchronous write port, one column read of all classes.
module clause_weight_ram #(
   parameter int NUM_CLAUSES = 16,
   parameter int NUM_CLASSES = 10,
   parameter int WEIGHT_W    = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               we,
   input  logic [$clog2(NUM_CLASSES)-1:0]     wr_class,
   input  logic [$clog2(NUM_CLAUSES)-1:0]     wr_clause,
   input  logic signed [WEIGHT_W-1:0]         wr_data,
   input  logic [$clog2(NUM_CLAUSES)-1:0]     rd_clause,
   output logic signed [WEIGHT_W-1:0]         rd_col [NUM_CLASSES]
);

   localparam int CL_W = $clog2(NUM_CLAUSES);
   localparam int CS_W = $clog2(NUM_CLASSES);

   logic signed [WEIGHT_W-1:0] mem_r [NUM_CLASSES][NUM_CLAUSES];
   logic                       in_range_s;

   // Non-power-of-two geometries leave unused address codes that must not write.
   assign in_range_s = ({1'b0, wr_class} < (CS_W + 1)'(NUM_CLASSES)) &&
                       ({1'b0, wr_clause} < (CL_W + 1)'(NUM_CLAUSES));

   // Weight storage with full clear on reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CLASSES; c++) begin
            for (int k = 0; k < NUM_CLAUSES; k++) begin
               mem_r[c][k] <= '0;
            end
         end
      end else if (we && in_range_s) begin
         mem_r[wr_class][wr_clause] <= wr_data;
      end
   end

   // Column read feeding every class accumulator in parallel.
   always_comb begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
         rd_col[c] = mem_r[c][rd_clause];
      end
   end

endmodule

// File: rtl/clause_class_sum.sv
// Clause OR-accumulation over patch positions, weighted per-class sums, then argmax with result handshake.
module clause_class_sum
   import clause_class_sum_pkg::*;
#(
   parameter int NUM_CLAUSES = DEF_NUM_CLAUSES,
   parameter int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int WEIGHT_W    = DEF_WEIGHT_W
) (
   input logic               clk,
   input logic               rst,
   clause_class_sum_if.slave bus
);

   localparam int SUM_W = sum_width(WEIGHT_W, NUM_CLAUSES);
   localparam int CL_W  = $clog2(NUM_CLAUSES);
   localparam int CS_W  = $clog2(NUM_CLASSES);

   state_t                     state_r;
   state_t                     state_n;
   logic [NUM_CLAUSES-1:0]     clause_or_r;
   logic signed [SUM_W-1:0]    sum_r [NUM_CLASSES];
   logic signed [SUM_W-1:0]    best_r;
   logic [CS_W-1:0]            best_idx_r;
   logic [CL_W-1:0]            clause_idx_r;
   logic [CS_W-1:0]            class_idx_r;
   logic                       busy_r;
   logic                       result_valid_r;
   logic [CS_W-1:0]            class_pred_r;
   logic signed [SUM_W-1:0]    class_sum_max_r;
   logic signed [WEIGHT_W-1:0] col_s [NUM_CLASSES];
   logic                       we_s;
   logic                       accept_s;

   assign accept_s = (state_r == ST_DONE) && result_valid_r && bus.result_ready;

   // Weights are frozen while SUM/ARGMAX are reading them.
   always_comb begin
      we_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_ACCUM, ST_DONE: we_s = bus.w_we;
         default:                    we_s = 1'b0;
      endcase
   end

   clause_weight_ram #(
      .NUM_CLAUSES (NUM_CLAUSES),
      .NUM_CLASSES (NUM_CLASSES),
      .WEIGHT_W    (WEIGHT_W)
   ) u_weight_ram (
      .clk       (clk),
      .rst       (rst),
      .we        (we_s),
      .wr_class  (bus.w_class),
      .wr_clause (bus.w_clause),
      .wr_data   (bus.w_data),
      .rd_clause (clause_idx_r),
      .rd_col    (col_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state logic.
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.img_start) state_n = ST_ACCUM;
            else               state_n = ST_IDLE;
         end
         ST_ACCUM: begin
            if (bus.clause_valid && bus.clause_last) state_n = ST_SUM;
            else                                     state_n = ST_ACCUM;
         end
         ST_SUM: begin
            if (clause_idx_r == CL_W'(NUM_CLAUSES - 1)) state_n = ST_ARGMAX;
            else                                        state_n = ST_SUM;
         end
         ST_ARGMAX: begin
            if (class_idx_r == CS_W'(NUM_CLASSES - 1)) state_n = ST_DONE;
            else                                       state_n = ST_ARGMAX;
         end
         ST_DONE: begin
            if (accept_s) state_n = ST_IDLE;
            else          state_n = ST_DONE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Datapath: clause OR, per-class accumulation, argmax scan.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clause_or_r  <= '0;
         clause_idx_r <= '0;
         class_idx_r  <= '0;
         best_r       <= '0;
         best_idx_r   <= '0;
         for (int c = 0; c < NUM_CLASSES; c++) sum_r[c] <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.img_start) clause_or_r <= bus.clause_valid ? bus.clause_vec : '0;
            end
            ST_ACCUM: begin
               if (bus.clause_valid) clause_or_r <= clause_or_r | bus.clause_vec;
               clause_idx_r <= '0;
               for (int c = 0; c < NUM_CLASSES; c++) sum_r[c] <= '0;
            end
            ST_SUM: begin
               for (int c = 0; c < NUM_CLASSES; c++) begin
                  if (clause_or_r[clause_idx_r]) sum_r[c] <= sum_r[c] + SUM_W'(col_s[c]);
               end
               clause_idx_r <= clause_idx_r + CL_W'(1);
               class_idx_r  <= '0;
            end
            ST_ARGMAX: begin
               // Class 0 seeds the scan; strict compare keeps ties on the lowest index.
               if ((class_idx_r == '0) || (sum_r[class_idx_r] > best_r)) begin
                  best_r     <= sum_r[class_idx_r];
                  best_idx_r <= class_idx_r;
               end
               class_idx_r <= class_idx_r + CS_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Output registers; result loads on the first DONE cycle and holds until accepted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_r          <= 1'b0;
         result_valid_r  <= 1'b0;
         class_pred_r    <= '0;
         class_sum_max_r <= '0;
      end else begin
         busy_r <= (state_n != ST_IDLE);
         if ((state_r == ST_DONE) && !result_valid_r) begin
            result_valid_r  <= 1'b1;
            class_pred_r    <= best_idx_r;
            class_sum_max_r <= best_r;
         end else if (accept_s) begin
            result_valid_r  <= 1'b0;
         end
      end
   end

   assign bus.busy          = busy_r;
   assign bus.result_valid  = result_valid_r;
   assign bus.class_pred    = class_pred_r;
   assign bus.class_sum_max = class_sum_max_r;

endmodule

// File: tb/tb_clause_class_sum.sv
// Scoreboard bench for clause_class_sum at 4 clauses, 3 classes, 8-bit weights.
module tb_clause_class_sum;

   localparam int NCL = 4;
   localparam int NCS = 3;
   localparam int WW  = 8;
   localparam int SW  = 11;

   typedef struct {
      logic [1:0]           pred;
      logic signed [SW-1:0] sum;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   exp_t sb [$];
   int   wts [NCS][NCL];
   logic [3:0] vec_q [$];
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   clause_class_sum_if #(.NUM_CLAUSES(NCL), .NUM_CLASSES(NCS), .WEIGHT_W(WW)) bus ();

   clause_class_sum #(.NUM_CLAUSES(NCL), .NUM_CLASSES(NCS), .WEIGHT_W(WW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle;
      bus.img_start = 1'b0; bus.clause_valid = 1'b0; bus.clause_vec = 4'b0000;
      bus.clause_last = 1'b0; bus.w_we = 1'b0; bus.w_class = 2'd0;
      bus.w_clause = 2'd0; bus.w_data = 8'sd0; bus.result_ready = 1'b0;
   endtask

   // Reference: sum the selected weights per class, strict-greater argmax from class 0.
   function automatic exp_t model(input logic [3:0] cor);
      exp_t e;
      int   s, best, idx;
      best = 0; idx = 0;
      for (int c = 0; c < NCS; c++) begin
         s = 0;
         for (int k = 0; k < NCL; k++) if (cor[k]) s += wts[c][k];
         if (c == 0 || s > best) begin best = s; idx = c; end
      end
      e.pred = 2'(idx);
      e.sum  = SW'(best);
      return e;
   endfunction

   task automatic set_basic_weights;
      wts = '{'{1, 1, 1, 1}, '{5, -2, 0, 0}, '{-1, 3, 3, 0}};
   endtask

   task automatic load_weights;
      for (int c = 0; c < NCS; c++) begin
         for (int k = 0; k < NCL; k++) begin
            bus.w_we = 1'b1; bus.w_class = 2'(c); bus.w_clause = 2'(k); bus.w_data = 8'(wts[c][k]);
            tick();
         end
      end
      bus.w_we = 1'b0;
   endtask

   task automatic send_image(output logic [3:0] cor);
      cor = 4'b0000;
      bus.img_start = 1'b1;
      tick();
      bus.img_start = 1'b0;
      for (int i = 0; i < vec_q.size(); i++) begin
         bus.clause_valid = 1'b1; bus.clause_vec = vec_q[i];
         bus.clause_last = (i == vec_q.size() - 1);
         cor = cor | vec_q[i];
         tick();
      end
      bus.clause_valid = 1'b0; bus.clause_last = 1'b0; bus.clause_vec = 4'b0000;
   endtask

   task automatic get_result(output int lat);
      lat = 0;
      while (bus.result_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      if (lat >= 100) lat = -1;
   endtask

   task automatic release_result;
      bus.result_ready = 1'b1;
      tick();
      bus.result_ready = 1'b0;
   endtask

   task automatic test_reset;
      drive_idle();
      rst = 1'b0;
      tick(); tick();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.result_valid); end
      n_checks++; if (bus.class_pred !== 2'd0) begin n_fail++; $display("FAIL reset_pred: got %0d expected 0", bus.class_pred); end
      n_checks++; if (bus.class_sum_max !== 11'sd0) begin n_fail++; $display("FAIL reset_sum: got %0d expected 0", bus.class_sum_max); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      logic [3:0] cor;
      exp_t e;
      int   lat;
      set_basic_weights();
      load_weights();
      vec_q = {4'b0001, 4'b0010, 4'b0100};
      send_image(cor);
      sb.push_back(model(cor));
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
      get_result(lat);
      e = sb.pop_front();
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d expected 8", lat); end
      n_checks++; if (bus.class_pred !== e.pred) begin n_fail++; $display("FAIL basic_pred: got %0d expected %0d", bus.class_pred, e.pred); end
      n_checks++; if (bus.class_sum_max !== e.sum) begin n_fail++; $display("FAIL basic_sum: got %0d expected %0d", bus.class_sum_max, e.sum); end
      n_checks++; if (bus.class_pred !== 2'd2) begin n_fail++; $display("FAIL basic_pred_const: got %0d expected 2", bus.class_pred); end
      n_checks++; if (bus.class_sum_max !== 11'sd5) begin n_fail++; $display("FAIL basic_sum_const: got %0d expected 5", bus.class_sum_max); end
      release_result();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_zero_weights;
      logic [3:0] cor;
      exp_t e;
      int   lat;
      foreach (wts[c, k]) wts[c][k] = 0;
      load_weights();
      vec_q = {4'b1111};
      send_image(cor);
      sb.push_back(model(cor));
      get_result(lat);
      e = sb.pop_front();
      n_checks++; if (lat < 0) begin n_fail++; $display("FAIL zero_timeout: got no result_valid expected one"); end
      n_checks++; if (bus.class_pred !== e.pred) begin n_fail++; $display("FAIL zero_pred: got %0d expected %0d", bus.class_pred, e.pred); end
      n_checks++; if (bus.class_sum_max !== e.sum) begin n_fail++; $display("FAIL zero_sum: got %0d expected %0d", bus.class_sum_max, e.sum); end
      release_result();
   endtask

   task automatic test_backpressure;
      logic [3:0] cor;
      exp_t e;
      int   lat;
      set_basic_weights();
      load_weights();
      vec_q = {4'b1010};
      send_image(cor);
      sb.push_back(model(cor));
      get_result(lat);
      e = sb.pop_front();
      n_checks++; if (lat < 0) begin n_fail++; $display("FAIL bp_timeout: got no result_valid expected one"); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (bus.result_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold: got %b expected 1", bus.result_valid); end
         n_checks++; if (bus.class_pred !== e.pred) begin n_fail++; $display("FAIL bp_pred: got %0d expected %0d", bus.class_pred, e.pred); end
         n_checks++; if (bus.class_sum_max !== e.sum) begin n_fail++; $display("FAIL bp_sum: got %0d expected %0d", bus.class_sum_max, e.sum); end
      end
      release_result();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b expected 0", bus.result_valid); end
   endtask

   task automatic test_reset_mid_sum;
      logic [3:0] cor;
      exp_t e;
      int   lat;
      vec_q = {4'b0001, 4'b0010, 4'b0100};
      send_image(cor);
      tick();
      rst = 1'b0;
      tick();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", bus.result_valid); end
      n_checks++; if (bus.class_pred !== 2'd0) begin n_fail++; $display("FAIL midrst_pred: got %0d expected 0", bus.class_pred); end
      n_checks++; if (bus.class_sum_max !== 11'sd0) begin n_fail++; $display("FAIL midrst_sum: got %0d expected 0", bus.class_sum_max); end
      rst = 1'b1;
      bus.clause_valid = 1'b1; bus.clause_vec = 4'b1111; bus.clause_last = 1'b1;
      tick();
      bus.clause_valid = 1'b0; bus.clause_last = 1'b0;
      tick();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL no_start_busy: got %b expected 0", bus.busy); end
      // Reset cleared the weight store.
      foreach (wts[c, k]) wts[c][k] = 0;
      vec_q = {4'b1111};
      send_image(cor);
      sb.push_back(model(cor));
      get_result(lat);
      e = sb.pop_front();
      n_checks++; if (bus.class_sum_max !== e.sum || lat < 0) begin n_fail++; $display("FAIL cleared_w_sum: got %0d expected %0d", bus.class_sum_max, e.sum); end
      release_result();
      set_basic_weights();
      load_weights();
      vec_q = {4'b0001, 4'b0010, 4'b0100};
      send_image(cor);
      sb.push_back(model(cor));
      get_result(lat);
      e = sb.pop_front();
      n_checks++; if (bus.class_pred !== e.pred || lat < 0) begin n_fail++; $display("FAIL rerun_pred: got %0d expected %0d", bus.class_pred, e.pred); end
      n_checks++; if (bus.class_sum_max !== 11'sd5) begin n_fail++; $display("FAIL rerun_sum: got %0d expected 5", bus.class_sum_max); end
      release_result();
   endtask

   task automatic test_ignored_inputs;
      logic [3:0] cor;
      exp_t e;
      int   lat;
      bus.img_start = 1'b1;
      tick();
      bus.clause_valid = 1'b1; bus.clause_vec = 4'b0001;
      tick();
      bus.img_start = 1'b0; bus.clause_vec = 4'b1000; bus.clause_last = 1'b1;
      tick();
      sb.push_back(model(4'b1001));
      // Stray clauses and a weight write while summing must not land.
      bus.clause_vec = 4'b0110;
      bus.w_we = 1'b1; bus.w_class = 2'd2; bus.w_clause = 2'd0; bus.w_data = 8'sd100;
      tick(); tick();
      drive_idle();
      get_result(lat);
      e = sb.pop_front();
      n_checks++; if (bus.class_pred !== e.pred || lat < 0) begin n_fail++; $display("FAIL ign_pred: got %0d expected %0d", bus.class_pred, e.pred); end
      n_checks++; if (bus.class_sum_max !== e.sum) begin n_fail++; $display("FAIL ign_sum: got %0d expected %0d", bus.class_sum_max, e.sum); end
      release_result();
      vec_q = {4'b0001};
      send_image(cor);
      sb.push_back(model(cor));
      get_result(lat);
      e = sb.pop_front();
      n_checks++; if (bus.class_pred !== e.pred || lat < 0) begin n_fail++; $display("FAIL ign_w_pred: got %0d expected %0d", bus.class_pred, e.pred); end
      n_checks++; if (bus.class_sum_max !== e.sum) begin n_fail++; $display("FAIL ign_w_sum: got %0d expected %0d", bus.class_sum_max, e.sum); end
      release_result();
   endtask

   task automatic test_back_to_back;
      logic [3:0] cor;
      exp_t e;
      int   lat;
      vec_q = {4'b0100};
      send_image(cor);
      sb.push_back(model(cor));
      get_result(lat);
      e = sb.pop_front();
      n_checks++; if (bus.class_pred !== e.pred || lat < 0) begin n_fail++; $display("FAIL b2b_first_pred: got %0d expected %0d", bus.class_pred, e.pred); end
      bus.w_we = 1'b1; bus.w_class = 2'd0; bus.w_clause = 2'd0; bus.w_data = 8'sd50;
      wts[0][0] = 50;
      tick();
      bus.w_we = 1'b0;
      release_result();
      vec_q = {4'b0001};
      send_image(cor);
      sb.push_back(model(cor));
      get_result(lat);
      e = sb.pop_front();
      n_checks++; if (bus.class_pred !== e.pred || lat < 0) begin n_fail++; $display("FAIL b2b_pred: got %0d expected %0d", bus.class_pred, e.pred); end
      n_checks++; if (bus.class_sum_max !== e.sum) begin n_fail++; $display("FAIL b2b_sum: got %0d expected %0d", bus.class_sum_max, e.sum); end
      release_result();
   endtask

   task automatic test_extremes;
      logic [3:0] cor;
      exp_t e;
      int   lat;
      wts = '{'{-128, -128, -128, -128}, '{127, 127, 127, 127}, '{0, 0, 0, 0}};
      load_weights();
      vec_q = {4'b1111};
      send_image(cor);
      sb.push_back(model(cor));
      get_result(lat);
      e = sb.pop_front();
      n_checks++; if (bus.class_pred !== e.pred || lat < 0) begin n_fail++; $display("FAIL max_pred: got %0d expected %0d", bus.class_pred, e.pred); end
      n_checks++; if (bus.class_sum_max !== 11'sd508) begin n_fail++; $display("FAIL max_sum: got %0d expected 508", bus.class_sum_max); end
      release_result();
      wts = '{'{-128, -128, -128, -128}, '{-128, -128, -128, -128}, '{-128, -128, -128, -128}};
      load_weights();
      send_image(cor);
      sb.push_back(model(cor));
      get_result(lat);
      e = sb.pop_front();
      n_checks++; if (bus.class_pred !== e.pred || lat < 0) begin n_fail++; $display("FAIL min_pred: got %0d expected %0d", bus.class_pred, e.pred); end
      n_checks++; if (bus.class_sum_max !== -11'sd512) begin n_fail++; $display("FAIL min_sum: got %0d expected -512", bus.class_sum_max); end
      release_result();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_weights();
      test_backpressure();
      test_reset_mid_sum();
      test_ignored_inputs();
      test_back_to_back();
      test_extremes();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1);
   end

endmodule

// File: doc/clause_class_sum.md
CLAUSE_CLASS_SUM -- requirements
Module: clause_class_sum

Interface
REQ-001 SHALL have parameter NUM_CLAUSES, default 16: number of clause_op bits presented per patch position.
REQ-002 SHALL have parameter NUM_CLASSES, default 10: number of output classes.
REQ-003 SHALL have parameter WEIGHT_W, default 8: signed two's-complement weight width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port img_start, input, 1: begins a new image; honoured only in IDLE.
REQ-007 SHALL have port clause_valid, input, 1: clause_vec is valid this cycle.
REQ-008 SHALL have port clause_vec, input, NUM_CLAUSES: per-clause clause_op for one patch position.
REQ-009 SHALL have port clause_last, input, 1: qualifies clause_valid and marks the final patch position.
REQ-010 SHALL have port w_we, input, 1: weight write enable.
REQ-011 SHALL have port w_class, input, clog2(NUM_CLASSES): weight row.
REQ-012 SHALL have port w_clause, input, clog2(NUM_CLAUSES): weight column.
REQ-013 SHALL have port w_data, input, WEIGHT_W: signed weight.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port result_valid, output, 1: high in DONE.
REQ-016 SHALL have port result_ready, input, 1: downstream acceptance.
REQ-017 SHALL have port class_pred, output, clog2(NUM_CLASSES): argmax class.
REQ-018 SHALL have port class_sum_max, output, SUM_W: signed winning sum; SUM_W = WEIGHT_W + clog2(NUM_CLAUSES) + 1.

Function
REQ-019 SHALL implement FSM IDLE, ACCUM, SUM, ARGMAX, DONE.
REQ-020 IDLE with img_start -> ACCUM; clause_or cleared; a clause_valid in the same cycle is OR-ed in.
REQ-021 ACCUM: on clause_valid, clause_or <= clause_or | clause_vec; with clause_last as well -> SUM next cycle.
REQ-022 clause_valid outside IDLE-with-img_start and ACCUM SHALL be ignored; img_start outside IDLE SHALL be ignored.
REQ-023 SUM SHALL last exactly NUM_CLAUSES cycles; in cycle k, for every class c, sum[c] += sign-extended weight[c][k] if clause_or[k] = 1; sums cleared on entry.
REQ-024 Sums SHALL NOT overflow at SUM_W; no saturation logic.
REQ-025 ARGMAX SHALL last exactly NUM_CLASSES cycles, scanning c = 0 upward; strict greater-than compare, so ties resolve to the lowest index.
REQ-026 result_valid SHALL first assert NUM_CLAUSES + NUM_CLASSES + 1 cycles after the clause_last acceptance edge.
REQ-027 DONE SHALL hold class_pred and class_sum_max stable until result_valid & result_ready, then -> IDLE next cycle.
REQ-028 A weight write SHALL take effect the next cycle in IDLE, ACCUM or DONE; w_we in SUM or ARGMAX SHALL be ignored.
REQ-029 An all-zero clause_or SHALL yield all sums 0, class_pred 0 and class_sum_max 0.

Reset
REQ-030 rst low at a clock edge SHALL force IDLE, clear clause_or, sums and all weights, and drive busy 0, result_valid 0, class_pred 0 and class_sum_max 0, including mid-SUM or mid-ARGMAX.
REQ-031 The first image after reset SHALL require a fresh img_start.

Structure
REQ-032 The FSM state encoding, the SUM_W formula and default parameter values SHALL live in the shared project package.
REQ-033 The weight store SHALL be a sub-module clause_weight_ram: NUM_CLASSES x NUM_CLAUSES registers, one synchronous write port, and one combinational read of column k returning all classes in parallel.

Verification (NUM_CLAUSES=4, NUM_CLASSES=3, WEIGHT_W=8)
REQ-034 Weights row0 = {+1,+1,+1,+1}, row1 = {+5,-2,0,0}, row2 = {-1,+3,+3,0}; patch vectors 0001, 0010, 0100 with last on the third -> clause_or 0111, sums {3,3,5}, class_pred 2, class_sum_max 5, result_valid 8 cycles after the last edge.
REQ-035 Weights all 0, single patch 1111 with last -> sums {0,0,0}, class_pred 0 (tie to lowest index).
REQ-036 Hold result_ready low for 5 cycles in DONE -> outputs stable and result_valid held; assert result_ready -> IDLE, busy 0 on the next cycle.
REQ-037 Drive rst low during the 2nd SUM cycle -> next cycle IDLE, all outputs 0; a following image with weights reloaded reproduces the REQ-034 result.
REQ-038 Issue img_start and clause_valid in ACCUM, and w_we during SUM -> ignored; class_pred and sums match the reference model.
REQ-039 Weights row1 = {+127,+127,+127,+127}, clause_or 1111 -> sum 508 without overflow; weights row0 = {-128,-128,-128,-128} -> sum -512.
